csamul_pipe: RTL and testbench

- Parametrised, pipelined carry-save array multiplier with a ripple-carry final adder. Generalises the flat 4-bit unsigned CSA/RCA multiplier in four ways:
  - N-bit operands.
  - Configurable number of partial-product rows reduced per pipeline stage.
  - Per-transaction signed/unsigned mode.
  - Valid/ready streaming with backpressure.
- Sits in the arithmetic datapath library as the throughput-oriented multiplier. Accepts one operand pair per cycle when not stalled.

---
 rtl/csamul_pipe.sv | 116 +++++++++++
 tb/tb_csamul_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/csamul_pipe.sv
`timescale 1ns/1ps
// Pipelined carry-save array multiplier: ROWS partial-product rows reduced per stage,
// per-transaction signed/unsigned mode, valid/ready streaming with a global stall.
module csamul_pipe #(
    parameter int N    = 4,
    parameter int ROWS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p
);
    localparam int S = (N + ROWS - 1) / ROWS;
    localparam int W = 2 * N;

    logic         stall;
    logic [S:0]   vld;
    logic [W-1:0] s_r  [S:0];
    logic [W-1:0] c_r  [S:0];
    logic [W-1:0] ap_r [S-1:0];
    logic [W-1:0] am_r [S-1:0];
    logic [N-1:0] b_r  [S-1:0];
    logic [W-1:0] s_nx [S:1];
    logic [W-1:0] c_nx [S:1];
    logic [W-1:0] a_ext;
    logic [W-1:0] a_msb;
    logic [W-1:0] s_t;
    logic [W-1:0] c_t;
    logic [W-1:0] s_t2;
    logic [W-1:0] pp;
    logic [N-1:0] hi_sum;
    logic         cy;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // In signed mode the multiplier MSB has negative weight, so its row uses -a.
    // Negating up front keeps every row zero below its own bit position, which is
    // what lets the low product bits settle one per row.
    always_comb begin
        a_ext = in_signed ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        a_msb = in_signed ? -a_ext : a_ext;
    end

    always_comb begin
        s_t  = '0;
        c_t  = '0;
        s_t2 = '0;
        pp   = '0;
        for (int j = 1; j <= S; j++) begin
            s_t = s_r[j-1];
            c_t = c_r[j-1];
            for (int i = (j - 1) * ROWS; (i < j * ROWS) && (i < N); i++) begin
                pp   = b_r[j-1][i] ? (((i == N - 1) ? am_r[j-1] : ap_r[j-1]) << i) : '0;
                s_t2 = s_t ^ c_t ^ pp;
                c_t  = ((s_t & c_t) | (s_t & pp) | (c_t & pp)) << 1;
                s_t  = s_t2;
            end
            s_nx[j] = s_t;
            c_nx[j] = c_t;
        end
    end

    // Carry vector is zero in the low N bits after the last row; only the top half needs adding.
    always_comb begin
        hi_sum = '0;
        cy     = 1'b0;
        for (int i = 0; i < N; i++) begin
            hi_sum[i] = s_r[S][N+i] ^ c_r[S][N+i] ^ cy;
            cy        = (s_r[S][N+i] & c_r[S][N+i]) | (cy & (s_r[S][N+i] ^ c_r[S][N+i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            for (int j = 0; j <= S; j++) begin
                s_r[j] <= '0;
                c_r[j] <= '0;
            end
            for (int j = 0; j < S; j++) begin
                ap_r[j] <= '0;
                am_r[j] <= '0;
                b_r[j]  <= '0;
            end
        end else if (!stall) begin
            vld     <= {vld[S-1:0], in_valid};
            s_r[0]  <= '0;
            c_r[0]  <= '0;
            ap_r[0] <= a_ext;
            am_r[0] <= a_msb;
            b_r[0]  <= b;
            for (int j = 1; j < S; j++) begin
                ap_r[j] <= ap_r[j-1];
                am_r[j] <= am_r[j-1];
                b_r[j]  <= b_r[j-1];
            end
            for (int j = 1; j <= S; j++) begin
                s_r[j] <= s_nx[j];
                c_r[j] <= c_nx[j];
            end
            out_valid <= vld[S];
            if (vld[S]) begin
                out_p <= {hi_sum, s_r[S][N-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_csamul_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for csamul_pipe: one N=4/ROWS=1 instance and one N=8/ROWS=3 instance.
module tb_csamul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv4, ir4, sg4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        iv8, ir8, sg8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] q4[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    csamul_pipe #(.N(4), .ROWS(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_signed(sg4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .out_p(p4)
    );

    csamul_pipe #(.N(8), .ROWS(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_signed(sg8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .out_p(p8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mref(input int n, input bit sg, input logic [7:0] x, input logic [7:0] y);
        longint ax, bx, p;
        ax = longint'(x);
        bx = longint'(y);
        if (sg && x[n-1]) ax = ax - (longint'(1) << n);
        if (sg && y[n-1]) bx = bx - (longint'(1) << n);
        p = ax * bx;
        return 64'(p) & ((64'(1) << (2 * n)) - 64'(1));
    endfunction

    // Inputs change only just after a rising edge, so values seen here are what the next edge samples.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            q8.delete();
        end else begin
            if (ov4 && or4) begin
                chk("sb4_pending", 64'(q4.size() > 0), 64'd1);
                if (q4.size() > 0) chk("sb4_data", 64'(p4), q4.pop_front());
            end
            if (iv4 && ir4) q4.push_back(mref(4, sg4, {4'b0, a4}, {4'b0, b4}));
            if (ov8 && or8) begin
                chk("sb8_pending", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0) chk("sb8_data", 64'(p8), q8.pop_front());
            end
            if (iv8 && ir8) q8.push_back(mref(8, sg8, a8, b8));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov4(output int lat);
        lat = 0;
        while (!ov4 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic drive4(input bit sg, input logic [3:0] x, input logic [3:0] y);
        iv4 = 1'b1;
        sg4 = sg;
        a4  = x;
        b4  = y;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         lat;
        int         n_hi;
        bit         seen;
        logic [7:0] pv;

        rst = 1'b1;
        iv4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
        iv8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        repeat (2) step();
        chk("rst_ov4", 64'(ov4), 64'd0);
        chk("rst_p4",  64'(p4),  64'd0);
        chk("rst_ir4", 64'(ir4), 64'd1);
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk("rst_p8",  64'(p8),  64'd0);
        rst = 1'b0;
        repeat (2) step();

        // single unsigned 15*15
        drive4(1'b0, 4'hF, 4'hF);
        iv4  = 1'b0;
        seen = 1'b0;
        lat  = 0;
        while (!ov4 && lat < 20) begin
            if (!ir4) seen = 1'b1;
            step();
            lat++;
        end
        chk("lat4_single", 64'(lat), 64'd5);
        chk("p4_15x15", 64'(p4), 64'hE1);
        chk("ir4_hold", 64'(seen), 64'd0);
        step();
        chk("ov4_pulse", 64'(ov4), 64'd0);

        // mixed signed/unsigned on consecutive cycles
        drive4(1'b1, 4'h8, 4'h8);
        drive4(1'b1, 4'hF, 4'h1);
        drive4(1'b0, 4'hF, 4'h1);
        iv4 = 1'b0;
        wait_ov4(lat);
        chk("p4_s8x8", 64'(p4), 64'h40);
        step();
        chk("ov4_seq2", 64'(ov4), 64'd1);
        chk("p4_sFx1", 64'(p4), 64'hFF);
        step();
        chk("ov4_seq3", 64'(ov4), 64'd1);
        chk("p4_uFx1", 64'(p4), 64'h0F);
        step();

        // exhaustive back-to-back stream, unsigned then signed
        n_hi = 0;
        for (int t = 0; t < 520; t++) begin
            if (t < 512) begin
                iv4 = 1'b1;
                {sg4, a4, b4} = 9'(t);
            end else begin
                iv4 = 1'b0;
            end
            step();
            if (t >= 5 && t < 517 && ov4) n_hi++;
        end
        chk("stream_contig", 64'(n_hi), 64'd512);
        chk("q4_after_stream", 64'(q4.size()), 64'd0);

        // backpressure with a full pipeline
        for (int t = 0; t < 8; t++) drive4(1'(t & 1), 4'($urandom), 4'($urandom));
        or4 = 1'b0;
        #1;
        chk("bp_ir_now", 64'(ir4), 64'd0);
        pv = p4;
        for (int t = 0; t < 7; t++) begin
            step();
            chk("bp_ir", 64'(ir4), 64'd0);
            chk("bp_ov", 64'(ov4), 64'd1);
            chk("bp_p",  64'(p4),  64'(pv));
        end
        or4 = 1'b1;
        step();
        iv4 = 1'b0;
        repeat (12) step();
        chk("q4_after_bp", 64'(q4.size()), 64'd0);

        // asynchronous reset with three transactions in flight
        drive4(1'b0, 4'h2, 4'h3);
        drive4(1'b0, 4'h4, 4'h5);
        drive4(1'b0, 4'h7, 4'h7);
        iv4 = 1'b0;
        wait_ov4(lat);
        chk("pre_rst_ov4", 64'(ov4), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov4", 64'(ov4), 64'd0);
        chk("arst_p4",  64'(p4),  64'd0);
        chk("arst_ir4", 64'(ir4), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (ov4) seen = 1'b1;
        end
        chk("no_stale", 64'(seen), 64'd0);
        drive4(1'b0, 4'h3, 4'h5);
        iv4 = 1'b0;
        wait_ov4(lat);
        chk("lat4_post_rst", 64'(lat), 64'd5);
        chk("p4_3x5", 64'(p4), 64'h0F);
        step();

        // N=8, ROWS=3: latency, then random stream with random backpressure
        iv8 = 1'b1; sg8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        step();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 20) begin
            step();
            lat++;
        end
        chk("lat8_single", 64'(lat), 64'd4);
        chk("p8_s80x80", 64'(p8), 64'h4000);
        step();
        for (int t = 0; t < 300; t++) begin
            iv8 = ($urandom_range(0, 3) != 0);
            sg8 = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            or8 = ($urandom_range(0, 3) != 0);
            step();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        repeat (10) step();
        chk("q8_drain", 64'(q8.size()), 64'd0);
        chk("q4_final", 64'(q4.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
